int_ctrl: RTL and testbench

- Four-source interrupt controller sitting directly upstream of the cpu core; produces the core's interrupt request, source id and handler vector.
- Synchronises and edge-detects raw request lines, latches them as pending, applies a mask, and resolves a fixed priority (source 0 highest).
- Runs a req/ack/eoi handshake with the core, one interrupt in service at a time.

---
 rtl/int_ctrl.sv | 156 +++++++++++++++
 tb/tb_int_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// ============================================================================
// int_ctrl : four-source fixed-priority interrupt controller (source 0 highest)
// Optional macro INTC_TIMER_EN: internal periodic timer drives source 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module int_ctrl #(
    parameter int                ADDR_W       = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE     = 10'h3F0,
    parameter int                TIMER_PERIOD = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        irq_in,
    input  logic              mask_we,
    input  logic [3:0]        mask_in,
    input  logic              int_ack,
    input  logic              int_eoi,
    output logic              int_req,
    output logic [1:0]        int_id,
    output logic [ADDR_W-1:0] int_vec,
    output logic [3:0]        pending,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0] state;
    logic [3:0] mask;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync3;
    logic [3:0] rise;
    logic [3:0] set_bits;
    logic [3:0] clr_bits;
    logic [3:0] active;
    logic [1:0] sel_id;

    // s3 resets low, so a line already high at reset release reads as one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            sync3 <= 4'b0000;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

`ifdef INTC_TIMER_EN
    localparam int CNT_W = (TIMER_PERIOD > 2) ? $clog2(TIMER_PERIOD) : 1;

    logic [CNT_W-1:0] tmr_count;
    logic             tmr_tick;

    assign tmr_tick = (tmr_count == CNT_W'(TIMER_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_count <= '0;
        end else if (tmr_tick) begin
            tmr_count <= '0;
        end else begin
            tmr_count <= tmr_count + 1'b1;
        end
    end

    // The timer replaces the external line 3 entirely
    assign set_bits = {tmr_tick, rise[2:0]};
`else
    assign set_bits = rise;
`endif

    assign active = pending & mask;

    always_comb begin
        sel_id = 2'd0;
        if (active[3]) sel_id = 2'd3;
        if (active[2]) sel_id = 2'd2;
        if (active[1]) sel_id = 2'd1;
        if (active[0]) sel_id = 2'd0;
    end

    always_comb begin
        clr_bits = 4'b0000;
        if (state == ST_REQ && int_ack) begin
            clr_bits[int_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= 4'b0000;
        end else if (mask_we) begin
            mask <= mask_in;
        end
    end

    // Set is applied after clear so a fresh edge on the acked source survives
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending & ~clr_bits) | set_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
            int_id  <= 2'd0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active != 4'b0000) begin
                        state   <= ST_REQ;
                        int_req <= 1'b1;
                        int_id  <= sel_id;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state   <= ST_SERVICE;
                        int_req <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (int_eoi) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    int_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign int_vec = VEC_BASE + (ADDR_W'(int_id) << 2);

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// tb_int_ctrl : scoreboard bench for int_ctrl (default build, no timer)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_eoi;
    logic       int_req;
    logic [1:0] int_id;
    logic [9:0] int_vec;
    logic [3:0] pending;
    logic       busy;

    int_ctrl #(
        .ADDR_W       (10),
        .VEC_BASE     (10'h3F0),
        .TIMER_PERIOD (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .int_ack (int_ack),
        .int_eoi (int_eoi),
        .int_req (int_req),
        .int_id  (int_id),
        .int_vec (int_vec),
        .pending (pending),
        .busy    (busy)
    );

    typedef struct {
        int         due;
        string      name;
        logic       req;
        logic [1:0] id;
        logic [9:0] vec;
        logic [3:0] pend;
        logic       bsy;
    } snap_t;

    typedef struct {
        logic [1:0] id;
        logic [9:0] vec;
    } reqexp_t;

    snap_t   exp_q[$];
    reqexp_t req_q[$];
    int      cyc;
    int      vectors;
    int      miscompares;
    logic    prev_req;
    logic    done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int n, input string nm, input logic req,
                             input logic [1:0] id, input logic [9:0] vec,
                             input logic [3:0] pend, input logic bsy);
        snap_t s;
        s.due  = cyc + n;
        s.name = nm;
        s.req  = req;
        s.id   = id;
        s.vec  = vec;
        s.pend = pend;
        s.bsy  = bsy;
        exp_q.push_back(s);
    endtask

    task automatic expect_req(input logic [1:0] id, input logic [9:0] vec);
        reqexp_t r;
        r.id  = id;
        r.vec = vec;
        req_q.push_back(r);
    endtask

    // Monitor: snapshot checks when due, request checks on each int_req rise
    initial begin
        snap_t   e;
        reqexp_t r;
        vectors     = 0;
        miscompares = 0;
        prev_req    = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                vectors = vectors + 1;
                if (e.due != cyc || int_req !== e.req || int_id !== e.id ||
                    int_vec !== e.vec || pending !== e.pend || busy !== e.bsy) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s @%0d: got req=%0b id=%0d vec=%h pend=%b busy=%0b, want req=%0b id=%0d vec=%h pend=%b busy=%0b",
                             e.name, cyc, int_req, int_id, int_vec, pending, busy,
                             e.req, e.id, e.vec, e.pend, e.bsy);
                end
            end
            if (int_req === 1'b1 && prev_req !== 1'b1) begin
                vectors = vectors + 1;
                if (req_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL unexpected_req @%0d: got id=%0d vec=%h, want no request",
                             cyc, int_id, int_vec);
                end else begin
                    r = req_q.pop_front();
                    if (int_id !== r.id || int_vec !== r.vec) begin
                        miscompares = miscompares + 1;
                        $display("FAIL req_order @%0d: got id=%0d vec=%h, want id=%0d vec=%h",
                                 cyc, int_id, int_vec, r.id, r.vec);
                    end
                end
            end
            prev_req = int_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        done    = 1'b0;
        reset   = 1'b1;
        irq_in  = 4'b0000;
        mask_we = 1'b0;
        mask_in = 4'b0000;
        int_ack = 1'b0;
        int_eoi = 1'b0;

        expect_at(2, "reset", 1'b0, 2'd0, 10'h3F0, 4'b0000, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
        mask_we = 1'b1; mask_in = 4'b1111;
        tick(1);
        mask_we = 1'b0;

        // Single source 2
        irq_in = 4'b0100;
        expect_at(3, "single_pend", 1'b0, 2'd0, 10'h3F0, 4'b0100, 1'b0);
        expect_at(4, "single_req",  1'b1, 2'd2, 10'h3F8, 4'b0100, 1'b0);
        expect_req(2'd2, 10'h3F8);
        tick(2); irq_in = 4'b0000; tick(2);
        int_ack = 1'b1;
        expect_at(1, "single_ack", 1'b0, 2'd2, 10'h3F8, 4'b0000, 1'b1);
        tick(1); int_ack = 1'b0; int_eoi = 1'b1;
        expect_at(1, "single_eoi", 1'b0, 2'd2, 10'h3F8, 4'b0000, 1'b0);
        tick(1); int_eoi = 1'b0; tick(2);

        // Priority: sources 1 and 3 together
        irq_in = 4'b1010;
        expect_at(3, "prio_pend", 1'b0, 2'd2, 10'h3F8, 4'b1010, 1'b0);
        expect_at(4, "prio_req1", 1'b1, 2'd1, 10'h3F4, 4'b1010, 1'b0);
        expect_req(2'd1, 10'h3F4);
        expect_req(2'd3, 10'h3FC);
        tick(2); irq_in = 4'b0000; tick(2);
        int_ack = 1'b1;
        expect_at(1, "prio_ack1", 1'b0, 2'd1, 10'h3F4, 4'b1000, 1'b1);
        tick(1); int_ack = 1'b0; int_eoi = 1'b1;
        expect_at(1, "prio_eoi1", 1'b0, 2'd1, 10'h3F4, 4'b1000, 1'b0);
        expect_at(2, "prio_req3", 1'b1, 2'd3, 10'h3FC, 4'b1000, 1'b0);
        tick(1); int_eoi = 1'b0; tick(1);
        int_ack = 1'b1; int_eoi = 1'b1;
        expect_at(1, "ack_eoi",  1'b0, 2'd3, 10'h3FC, 4'b0000, 1'b1);
        expect_at(2, "svc_hold", 1'b0, 2'd3, 10'h3FC, 4'b0000, 1'b1);
        tick(1); int_ack = 1'b0; int_eoi = 1'b0; tick(1);
        int_eoi = 1'b1;
        expect_at(1, "prio_eoi3", 1'b0, 2'd3, 10'h3FC, 4'b0000, 1'b0);
        tick(1); int_eoi = 1'b0; tick(1);

        // Masking
        mask_we = 1'b1; mask_in = 4'b0000;
        tick(1); mask_we = 1'b0;
        irq_in = 4'b0001;
        expect_at(3, "mask_pend", 1'b0, 2'd3, 10'h3FC, 4'b0001, 1'b0);
        expect_at(5, "mask_hold", 1'b0, 2'd3, 10'h3FC, 4'b0001, 1'b0);
        tick(2); irq_in = 4'b0000; tick(3);
        int_ack = 1'b1;
        expect_at(1, "ack_idle", 1'b0, 2'd3, 10'h3FC, 4'b0001, 1'b0);
        tick(1); int_ack = 1'b0;
        mask_we = 1'b1; mask_in = 4'b0001;
        expect_at(1, "mask_wr",  1'b0, 2'd3, 10'h3FC, 4'b0001, 1'b0);
        expect_at(2, "mask_req", 1'b1, 2'd0, 10'h3F0, 4'b0001, 1'b0);
        expect_req(2'd0, 10'h3F0);
        tick(1); mask_we = 1'b0; tick(1);
        int_ack = 1'b1;
        expect_at(1, "mask_ack", 1'b0, 2'd0, 10'h3F0, 4'b0000, 1'b1);
        tick(1); int_ack = 1'b0; int_eoi = 1'b1;
        expect_at(1, "mask_eoi", 1'b0, 2'd0, 10'h3F0, 4'b0000, 1'b0);
        tick(1); int_eoi = 1'b0;
        mask_we = 1'b1; mask_in = 4'b1111;
        tick(1); mask_we = 1'b0; tick(1);

        // Re-trigger: second edge on source 2 lands in the ack cycle
        irq_in = 4'b0100;
        expect_at(3, "retrig_pend", 1'b0, 2'd0, 10'h3F0, 4'b0100, 1'b0);
        expect_at(4, "retrig_req",  1'b1, 2'd2, 10'h3F8, 4'b0100, 1'b0);
        expect_req(2'd2, 10'h3F8);
        tick(1); irq_in = 4'b0000;
        tick(1); irq_in = 4'b0100;
        tick(2); irq_in = 4'b0000;
        int_ack = 1'b1;
        expect_at(1, "retrig_ack", 1'b0, 2'd2, 10'h3F8, 4'b0100, 1'b1);
        tick(1); int_ack = 1'b0;

        // Reset while in service
        reset = 1'b1;
        expect_at(1, "reset_svc", 1'b0, 2'd0, 10'h3F0, 4'b0000, 1'b0);
        tick(1); reset = 1'b0;
        expect_at(5, "post_reset", 1'b0, 2'd0, 10'h3F0, 4'b0000, 1'b0);
        tick(7);

        while (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL %s: got never checked, want check at cycle %0d", e.name, e.due);
        end
        while (req_q.size() > 0) begin
            reqexp_t r;
            r = req_q.pop_front();
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL missing_req: got no request, want id=%0d vec=%h", r.id, r.vec);
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
